// File: rtl/mult_pkg.sv
// Shared definitions for the serial multiplier and its operand serializer:
// FSM state encoding, default operand/frame widths and a counter-width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int MULT_A_W     = 10;
    localparam int MULT_B_W     = 10;
    localparam int MULT_FRAME_W = 32;
    localparam int MULT_GAP_CYC = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_operand_serializer.sv
// Packs operands A and B into a zero-padded frame, strobes the multiplier start
// and shifts the frame out LSB-first, then holds off for a guard interval.
module mult_operand_serializer
    import mult_pkg::*;
#(
    parameter int A_W     = MULT_A_W,
    parameter int B_W     = MULT_B_W,
    parameter int FRAME_W = MULT_FRAME_W,
    parameter int GAP_CYC = MULT_GAP_CYC
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [A_W-1:0] op_a,
    input  logic [B_W-1:0] op_b,
    input  logic           op_valid,
    output logic           op_ready,
    output logic           ctrl,
    output logic           in,
    output logic           busy,
    output logic           frame_done
);

    localparam int CNT_W = cnt_width(FRAME_W);
    localparam int GAP_W = cnt_width(GAP_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC);

    if (FRAME_W < A_W + B_W) begin : g_frame_too_narrow
        $error("mult_operand_serializer: FRAME_W must be >= A_W + B_W");
    end

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] packed_frame;

    assign op_ready = (state == IDLE);

    // Frame layout: A in the LSBs, B directly above, remaining bits zero.
    always_comb begin
        packed_frame                 = '0;
        packed_frame[A_W-1:0]        = op_a;
        packed_frame[A_W+B_W-1:A_W]  = op_b;
    end

    // Control FSM; outputs follow the state by one registered cycle. The first
    // GAP cycle still carries the last data bit on the line, so GAP always lasts
    // GAP_CYC+1 state cycles and yields exactly GAP_CYC idle bits on `in`.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ctrl       <= 1'b0;
            in         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            frame      <= '0;
        end else begin
            ctrl       <= 1'b0;
            in         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        state <= START;
                        frame <= packed_frame;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                START: begin
                    ctrl    <= 1'b1;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    in <= frame[bit_cnt];
                    if (bit_cnt == LAST_BIT) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    frame_done <= (gap_cnt == '0);
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_operand_serializer.sv
// Directed bench for mult_operand_serializer: one instance with a 4-cycle guard,
// one with no guard; per-cycle captures compared against hand-derived timing.
module tb_mult_operand_serializer;

    localparam int FW   = 32;
    localparam int GAP4 = 4;
    // Column indices into the capture record.
    localparam int C_CTRL = 0;
    localparam int C_IN   = 1;
    localparam int C_BUSY = 2;
    localparam int C_DONE = 3;
    localparam int C_RDY  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] a4, b4, a0, b0;
    logic       v4, v0;
    logic       rdy4, ctrl4, ser4, busy4, done4;
    logic       rdy0, ctrl0, ser0, busy0, done0;

    int checks = 0;
    int errors = 0;
    logic [4:0] cap [0:127];

    always #5 clk = ~clk;

    mult_operand_serializer #(.A_W(10), .B_W(10), .FRAME_W(FW), .GAP_CYC(GAP4)) u_dut (
        .clk(clk), .rst_n(rst_n), .op_a(a4), .op_b(b4), .op_valid(v4),
        .op_ready(rdy4), .ctrl(ctrl4), .in(ser4), .busy(busy4), .frame_done(done4)
    );

    mult_operand_serializer #(.A_W(10), .B_W(10), .FRAME_W(FW), .GAP_CYC(0)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n), .op_a(a0), .op_b(b0), .op_valid(v0),
        .op_ready(rdy0), .ctrl(ctrl0), .in(ser0), .busy(busy0), .frame_done(done0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_frame(input logic [9:0] a, input logic [9:0] b);
        return {12'd0, b, a};
    endfunction

    function automatic logic [31:0] word_at(input int start);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < FW; j++) w[j] = cap[start + j][C_IN];
        return w;
    endfunction

    function automatic int count_col(input int col, input int lo, input int hi);
        int n;
        n = 0;
        for (int k = lo; k <= hi; k++) if (cap[k][col] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_col(input int col, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (cap[k][col] === 1'b1) return k;
        return -1;
    endfunction

    // Handshake on the next edge, then record outputs on each falling edge:
    // cap[k] holds the values present after the k-th rising edge past the handshake.
    task automatic run(input bit nogap, input logic [9:0] a, input logic [9:0] b,
                       input bit hold, input int ncyc);
        @(negedge clk);
        if (nogap) begin a0 = a; b0 = b; v0 = 1'b1; end
        else       begin a4 = a; b4 = b; v4 = 1'b1; end
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (!hold) begin v0 = 1'b0; v4 = 1'b0; end
            if (nogap) cap[k] = {rdy0, done0, busy0, ser0, ctrl0};
            else       cap[k] = {rdy4, done4, busy4, ser4, ctrl4};
        end
        v0 = 1'b0;
        v4 = 1'b0;
    endtask

    task automatic wait_idle(input bit nogap);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!(nogap ? busy0 : busy4)) return;
        end
        check("idle_timeout", nogap ? busy0 : busy4, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        a4 = '0; b4 = '0; v4 = 1'b0;
        a0 = '0; b0 = '0; v0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", ctrl4, 0);
        check("rst_in",   ser4,  0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready",       rdy4, 1);
        check("rst_ready_nogap", rdy0, 1);

        // A=10, B=555: strobe at cycle 1, bits at 2..33, done at 34, ready at 38.
        run(1'b0, 10'd10, 10'd555, 1'b0, 44);
        check("t2_word",      word_at(2), 32'h0008_AC0A);
        check("t2_ctrl_pos",  first_col(C_CTRL, 0, 43), 1);
        check("t2_ctrl_cnt",  count_col(C_CTRL, 0, 43), 1);
        check("t2_in_strobe", cap[1][C_IN], 0);
        check("t2_done_pos",  first_col(C_DONE, 0, 43), 34);
        check("t2_done_cnt",  count_col(C_DONE, 0, 43), 1);
        check("t2_gap_zero",  count_col(C_IN, 34, 43), 0);
        check("t2_busy_cnt",  count_col(C_BUSY, 0, 43), 38);
        check("t2_ready_pos", first_col(C_RDY, 0, 43), 2 + FW + GAP4);

        // op_valid held: ready returns at 38, the next handshake is sampled on the
        // following edge and its strobe appears one cycle after that.
        run(1'b0, 10'd7, 10'd9, 1'b1, 78);
        check("t3_ready_pos", first_col(C_RDY, 0, 77), 2 + FW + GAP4);
        check("t3_ctrl2_pos", first_col(C_CTRL, 2, 77), 2 + FW + GAP4 + 2);
        check("t3_ctrl_cnt",  count_col(C_CTRL, 0, 77), 2);
        check("t3_word2",     word_at(2 + FW + GAP4 + 3), model_frame(10'd7, 10'd9));
        wait_idle(1'b0);

        // No guard: ready comes back with frame_done; back-to-back all-ones operands.
        run(1'b1, 10'd1023, 10'd1023, 1'b1, 71);
        check("t4_done_pos",  first_col(C_DONE, 0, 70), 34);
        check("t4_ready_pos", first_col(C_RDY, 0, 70), 34);
        check("t4_word1",     word_at(2), 32'h000F_FFFF);
        check("t4_ctrl2_pos", first_col(C_CTRL, 2, 70), 36);
        check("t4_word2",     word_at(37), 32'h000F_FFFF);
        check("t4_done2_pos", first_col(C_DONE, 35, 70), 69);
        wait_idle(1'b1);

        // Reset while bit 15 is on the line aborts the frame with no frame_done.
        run(1'b0, 10'd0, 10'h3FF, 1'b0, 18);
        check("t5_bit15", cap[17][C_IN], model_frame(10'd0, 10'h3FF) >> 15 & 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_in",   ser4,  0);
        check("t5_async_busy", busy4, 0);
        check("t5_async_ctrl", ctrl4, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 3) rst_n = 1'b1;
            cap[k] = {rdy4, done4, busy4, ser4, ctrl4};
        end
        check("t5_no_done",  count_col(C_DONE, 0, 39), 0);
        check("t5_idle_rdy", cap[39][C_RDY], 1);
        run(1'b0, 10'd3, 10'd5, 1'b0, 44);
        check("t5_ctrl_pos", first_col(C_CTRL, 0, 43), 1);
        check("t5_word",     word_at(2), 32'h0000_1403);

        // Zero operands: one strobe, 32 zero bits, busy for 38 cycles.
        run(1'b0, 10'd0, 10'd0, 1'b0, 44);
        check("t6_ctrl_cnt", count_col(C_CTRL, 0, 43), 1);
        check("t6_word",     word_at(2), 32'h0);
        check("t6_busy_cnt", count_col(C_BUSY, 0, 43), 38);
        check("t6_done_pos", first_col(C_DONE, 0, 43), 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
